vend_credit_fsm: RTL and testbench



---
 rtl/vend_pkg.sv | 8 +
 rtl/vend_coin_decode.sv | 19 +
 rtl/vend_credit_fsm.sv | 94 +++++++++
 tb/tb_vend_credit_fsm.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// vend_pkg: shared state and coin encodings for the vending credit controller
package vend_pkg;
    typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;
    localparam logic [1:0] COIN_NICKEL  = 2'b00;
    localparam logic [1:0] COIN_DIME    = 2'b01;
    localparam logic [1:0] COIN_QUARTER = 2'b10;
    localparam logic [1:0] COIN_ILLEGAL = 2'b11;
endpackage

// File: rtl/vend_coin_decode.sv
// vend_coin_decode: maps coin_type to its nickel value and a legal flag
module vend_coin_decode
    import vend_pkg::*;
#(
    parameter int CREDIT_W    = 5,
    parameter int DIME_VAL    = 2,
    parameter int QUARTER_VAL = 5
) (
    input  logic [1:0]        coin_type,
    output logic [CREDIT_W:0] value,
    output logic              legal
);
    localparam int VW = CREDIT_W + 1;

    assign legal = coin_type != COIN_ILLEGAL;
    assign value = coin_type == COIN_NICKEL  ? VW'(1) :
                   coin_type == COIN_DIME    ? VW'(DIME_VAL) :
                   coin_type == COIN_QUARTER ? VW'(QUARTER_VAL) : '0;
endmodule

// File: rtl/vend_credit_fsm.sv
// vend_credit_fsm: coin credit accumulator, vend and nickel refund; VEND_SALES_CNT_EN adds sales_count
module vend_credit_fsm
    import vend_pkg::*;
#(
    parameter int CREDIT_W    = 5,
    parameter int PRICE       = 3,
    parameter int DIME_VAL    = 2,
    parameter int QUARTER_VAL = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                coin_valid,
    input  logic [1:0]          coin_type,
    input  logic                cancel,
    output logic                vend,
    output logic                change_nickel,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
`ifdef VEND_SALES_CNT_EN
    ,
    output logic [15:0]         sales_count
`endif
);
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

    state_t              state;
    logic [CREDIT_W:0]   value;
    logic                legal;
    logic [CREDIT_W:0]   sum;
    logic [CREDIT_W-1:0] remainder;
    logic                accept;

    vend_coin_decode #(
        .CREDIT_W(CREDIT_W),
        .DIME_VAL(DIME_VAL),
        .QUARTER_VAL(QUARTER_VAL)
    ) u_decode (
        .coin_type(coin_type),
        .value(value),
        .legal(legal)
    );

    // the carry bit of the widened sum flags a coin that would overflow credit
    assign sum       = {1'b0, credit} + value;
    assign accept    = legal && !sum[CREDIT_W];
    assign remainder = credit - PRICE_C;

    assign vend          = state == VEND;
    assign change_nickel = state == CHANGE;
    assign busy          = state == VEND || state == CHANGE;

    // credit/state sequencing; any coin not taken into credit is flagged next cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            credit      <= '0;
            coin_reject <= 1'b0;
        end else begin
            coin_reject <= 1'b0;
            case (state)
                IDLE, CREDIT: begin
                    if (state == CREDIT && cancel) begin
                        state       <= CHANGE;
                        coin_reject <= coin_valid;
                    end else if (coin_valid && accept) begin
                        credit <= sum[CREDIT_W-1:0];
                        state  <= sum >= (CREDIT_W+1)'(PRICE) ? VEND : CREDIT;
                    end else if (coin_valid) begin
                        coin_reject <= 1'b1;
                    end
                end
                VEND: begin
                    credit      <= remainder;
                    state       <= remainder != '0 ? CHANGE : IDLE;
                    coin_reject <= coin_valid;
                end
                CHANGE: begin
                    credit      <= credit - 1'b1;
                    state       <= credit == CREDIT_W'(1) ? IDLE : CHANGE;
                    coin_reject <= coin_valid;
                end
            endcase
        end
    end

`ifdef VEND_SALES_CNT_EN
    // completed sales, wrapping at 16 bits
    always_ff @(posedge clock) begin
        if (reset) sales_count <= '0;
        else if (state == VEND) sales_count <= sales_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_vend_credit_fsm.sv
// tb_vend_credit_fsm: directed-vector bench for vend_credit_fsm
module tb_vend_credit_fsm;
    localparam logic [3:0] NO = 4'b0000;
    localparam logic [3:0] NI = 4'b1000;
    localparam logic [3:0] DI = 4'b1010;
    localparam logic [3:0] QU = 4'b1100;
    localparam logic [3:0] IL = 4'b1110;
    localparam logic [3:0] CA = 4'b0001;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic cv0 = 1'b0, cn0 = 1'b0, cv1 = 1'b0, cn1 = 1'b0;
    logic [1:0] ct0 = 2'b00, ct1 = 2'b00;
    logic vend0, chg0, rej0, busy0, vend1, chg1, rej1, busy1;
    logic [4:0] credit0;
    logic [2:0] credit1;
    logic [8:0] obs0;
    logic [6:0] obs1;
    int vectors = 0;
    int errors = 0;
`ifdef VEND_SALES_CNT_EN
    logic [15:0] sales0, sales1;
`endif

    assign obs0 = {vend0, chg0, rej0, busy0, credit0};
    assign obs1 = {vend1, chg1, rej1, busy1, credit1};

    always #5 clock = ~clock;

    vend_credit_fsm u_d0 (
        .clock(clock), .reset(reset), .coin_valid(cv0), .coin_type(ct0), .cancel(cn0),
        .vend(vend0), .change_nickel(chg0), .coin_reject(rej0), .credit(credit0), .busy(busy0)
`ifdef VEND_SALES_CNT_EN
        , .sales_count(sales0)
`endif
    );

    vend_credit_fsm #(.CREDIT_W(3), .PRICE(7)) u_d1 (
        .clock(clock), .reset(reset), .coin_valid(cv1), .coin_type(ct1), .cancel(cn1),
        .vend(vend1), .change_nickel(chg1), .coin_reject(rej1), .credit(credit1), .busy(busy1)
`ifdef VEND_SALES_CNT_EN
        , .sales_count(sales1)
`endif
    );

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        vectors++;
        if (obs0 !== 9'd0) begin errors++; $display("FAIL reset_d0: got %b expected %b", obs0, 9'd0); end
        vectors++;
        if (obs1 !== 7'd0) begin errors++; $display("FAIL reset_d1: got %b expected %b", obs1, 7'd0); end
`ifdef VEND_SALES_CNT_EN
        vectors++;
        if (sales0 !== 16'd0) begin errors++; $display("FAIL reset_sales: got %0d expected 0", sales0); end
`endif
        reset = 1'b0;
    endtask

    task automatic test_nickels();
        logic [3:0] st [5] = '{NI, NI, NI, NO, NO};
        logic [8:0] ex [5] = '{{4'b0000, 5'd1}, {4'b0000, 5'd2}, {4'b1001, 5'd3},
                              {4'b0000, 5'd0}, {4'b0000, 5'd0}};
        for (int i = 0; i < 5; i++) begin
            {cv0, ct0, cn0} = st[i];
            @(posedge clock);
            #1;
            vectors++;
            if (obs0 !== ex[i]) begin errors++; $display("FAIL nickels[%0d]: got %b expected %b", i, obs0, ex[i]); end
        end
        {cv0, ct0, cn0} = NO;
    endtask

    task automatic test_change();
        logic [3:0] st [7] = '{DI, QU, NO, NO, NO, NO, NO};
        logic [8:0] ex [7] = '{{4'b0000, 5'd2}, {4'b1001, 5'd7}, {4'b0101, 5'd4}, {4'b0101, 5'd3},
                              {4'b0101, 5'd2}, {4'b0101, 5'd1}, {4'b0000, 5'd0}};
        for (int i = 0; i < 7; i++) begin
            {cv0, ct0, cn0} = st[i];
            @(posedge clock);
            #1;
            vectors++;
            if (obs0 !== ex[i]) begin errors++; $display("FAIL change[%0d]: got %b expected %b", i, obs0, ex[i]); end
        end
        {cv0, ct0, cn0} = NO;
    endtask

    task automatic test_cancel();
        logic [3:0] st [9] = '{DI, CA, NO, NO, CA, CA, NI, NI | CA, NO};
        logic [8:0] ex [9] = '{{4'b0000, 5'd2}, {4'b0101, 5'd2}, {4'b0101, 5'd1}, {4'b0000, 5'd0},
                              {4'b0000, 5'd0}, {4'b0000, 5'd0}, {4'b0000, 5'd1}, {4'b0111, 5'd1},
                              {4'b0000, 5'd0}};
        for (int i = 0; i < 9; i++) begin
            {cv0, ct0, cn0} = st[i];
            @(posedge clock);
            #1;
            vectors++;
            if (obs0 !== ex[i]) begin errors++; $display("FAIL cancel[%0d]: got %b expected %b", i, obs0, ex[i]); end
        end
        {cv0, ct0, cn0} = NO;
    endtask

    task automatic test_reject();
        logic [3:0] st [8] = '{IL, DI, QU, NO, NI, NO, NO, NO};
        logic [8:0] ex [8] = '{{4'b0010, 5'd0}, {4'b0000, 5'd2}, {4'b1001, 5'd7}, {4'b0101, 5'd4},
                              {4'b0111, 5'd3}, {4'b0101, 5'd2}, {4'b0101, 5'd1}, {4'b0000, 5'd0}};
        for (int i = 0; i < 8; i++) begin
            {cv0, ct0, cn0} = st[i];
            @(posedge clock);
            #1;
            vectors++;
            if (obs0 !== ex[i]) begin errors++; $display("FAIL reject[%0d]: got %b expected %b", i, obs0, ex[i]); end
        end
        {cv0, ct0, cn0} = NO;
    endtask

    task automatic test_overflow();
        logic [3:0] st [4] = '{QU, QU, DI, NO};
        logic [6:0] ex [4] = '{{4'b0000, 3'd5}, {4'b0010, 3'd5}, {4'b1001, 3'd7}, {4'b0000, 3'd0}};
        for (int i = 0; i < 4; i++) begin
            {cv1, ct1, cn1} = st[i];
            @(posedge clock);
            #1;
            vectors++;
            if (obs1 !== ex[i]) begin errors++; $display("FAIL overflow[%0d]: got %b expected %b", i, obs1, ex[i]); end
        end
        {cv1, ct1, cn1} = NO;
    endtask

    task automatic test_reset_mid_change();
        logic [4:0] st [6] = '{{1'b1, NO}, {1'b0, DI}, {1'b0, QU}, {1'b0, NO}, {1'b1, NO}, {1'b0, NO}};
        logic [8:0] ex [6] = '{{4'b0000, 5'd0}, {4'b0000, 5'd2}, {4'b1001, 5'd7}, {4'b0101, 5'd4},
                              {4'b0000, 5'd0}, {4'b0000, 5'd0}};
`ifdef VEND_SALES_CNT_EN
        logic [15:0] es [6] = '{16'd0, 16'd0, 16'd0, 16'd1, 16'd0, 16'd0};
`endif
        for (int i = 0; i < 6; i++) begin
            {reset, cv0, ct0, cn0} = st[i];
            @(posedge clock);
            #1;
            vectors++;
            if (obs0 !== ex[i]) begin errors++; $display("FAIL rst_change[%0d]: got %b expected %b", i, obs0, ex[i]); end
`ifdef VEND_SALES_CNT_EN
            vectors++;
            if (sales0 !== es[i]) begin errors++; $display("FAIL sales[%0d]: got %0d expected %0d", i, sales0, es[i]); end
`endif
        end
        {reset, cv0, ct0, cn0} = 5'd0;
    endtask

    initial begin
        test_reset();
        test_nickels();
        test_change();
        test_cancel();
        test_reject();
        test_overflow();
        test_reset_mid_change();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
